keyboard_scanner: RTL and testbench



---
 rtl/keyboard_pkg.sv | 15 +
 rtl/kb_col_debouncer.sv | 51 +++++
 rtl/keyboard_scanner.sv | 120 ++++++++++++
 tb/tb_keyboard_scanner.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared sizes and scan FSM encoding for the front-panel keyboard matrix scanner.
package keyboard_pkg;
   localparam int KB_COLS  = 8;
   localparam int KB_ROWS  = 5;
   localparam int KB_COL_W = $clog2(KB_COLS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_UPDATE,
      ST_UPDATE_RD
   } kb_scan_state_t;
endpackage

// File: rtl/kb_col_debouncer.sv
// Per-column candidate/count/committed row store; accept_o is combinational in the UPDATE cycle.
// The write is applied on the clock edge that ends UPDATE, together with the registered strobe.
module kb_col_debouncer
   import keyboard_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic                upd_i,
   input  logic [KB_COL_W-1:0] col_i,
   input  logic [KB_ROWS-1:0]  sample_i,
   output logic                accept_o,
   output logic [KB_ROWS-1:0]  pattern_o
);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

   logic [KB_ROWS-1:0] cand_q [KB_COLS];
   logic [CW-1:0]      cnt_q  [KB_COLS];
   logic [KB_ROWS-1:0] comm_q [KB_COLS];
   logic [KB_ROWS-1:0] cand_d;
   logic [CW-1:0]      cnt_d;

   always_comb begin
      cand_d = cand_q[col_i];
      cnt_d  = cnt_q[col_i];
      if (sample_i != cand_d) begin
         cand_d = sample_i;
         cnt_d  = CW'(1);
      end else if (cnt_d < CNT_MAX) begin
         cnt_d = cnt_d + 1'b1;
      end
      accept_o  = upd_i && (cnt_d == CNT_MAX) && (cand_d != comm_q[col_i]);
      pattern_o = cand_d;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < KB_COLS; i++) begin
            cand_q[i] <= '0;
            cnt_q[i]  <= '0;
            comm_q[i] <= '0;
         end
      end else if (upd_i) begin
         cand_q[col_i] <= cand_d;
         cnt_q[col_i]  <= cnt_d;
         if (accept_o) comm_q[col_i] <= cand_d;
      end
   end
endmodule

// File: rtl/keyboard_scanner.sv
// Column-by-column matrix scan with debounce; SETTLE_CYCLES+3 clocks per column, +1 when read fires.
// read/kbCol/kbRow are registered and stable for the whole read cycle (downstream clock gate).
module keyboard_scanner
   import keyboard_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         En,
   input  logic [6:0]   kbRowRaw,
   output logic [7:0]   kbCol,
   output logic [6:0]   kbRow,
   output logic         read,
   output logic         frameDone
);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   kb_scan_state_t      state_q, state_d;
   logic [KB_COL_W-1:0] col_q, col_d;
   logic [SW-1:0]       settle_q, settle_d;
   logic [KB_ROWS-1:0]  sync1_q, sync2_q;
   logic [KB_ROWS-1:0]  sample_q, sample_d;
   logic [KB_COLS-1:0]  kb_col_q, kb_col_d;
   logic [6:0]          kb_row_q, kb_row_d;
   logic                read_q, read_d;
   logic                frame_q, frame_d;
   logic                upd;
   logic                accept;
   logic [KB_ROWS-1:0]  pattern;
   logic                unused_rows;

   assign unused_rows = ^kbRowRaw[6:5];

   kb_col_debouncer #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .upd_i    (upd),
      .col_i    (col_q),
      .sample_i (sample_q),
      .accept_o (accept),
      .pattern_o(pattern)
   );

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      settle_d = settle_q;
      sample_d = sample_q;
      read_d   = 1'b0;
      kb_row_d = '0;
      frame_d  = 1'b0;
      upd      = 1'b0;
      case (state_q)
         ST_IDLE: if (En) state_d = ST_DRIVE;
         ST_DRIVE: begin
            settle_d = SW'(SETTLE_CYCLES - 1);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == '0) state_d = ST_SAMPLE;
            else                settle_d = settle_q - 1'b1;
         end
         ST_SAMPLE: begin
            sample_d = sync2_q;
            state_d  = ST_UPDATE;
         end
         ST_UPDATE: begin
            upd     = 1'b1;
            col_d   = col_q + 1'b1;
            frame_d = (col_q == KB_COL_W'(KB_COLS - 1));
            if (accept) begin
               read_d   = 1'b1;
               kb_row_d = {2'b00, pattern};
               state_d  = ST_UPDATE_RD;
            end else begin
               state_d  = En ? ST_DRIVE : ST_IDLE;
            end
         end
         ST_UPDATE_RD: state_d = En ? ST_DRIVE : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Column drive only changes on entry to DRIVE/IDLE, so it holds through any read cycle.
      kb_col_d = kb_col_q;
      if (state_d == ST_DRIVE)     kb_col_d = KB_COLS'(1) << col_d;
      else if (state_d == ST_IDLE) kb_col_d = '0;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         col_q    <= '0;
         settle_q <= '0;
         sync1_q  <= '0;
         sync2_q  <= '0;
         sample_q <= '0;
         kb_col_q <= '0;
         kb_row_q <= '0;
         read_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         settle_q <= settle_d;
         sync1_q  <= kbRowRaw[KB_ROWS-1:0];
         sync2_q  <= sync1_q;
         sample_q <= sample_d;
         kb_col_q <= kb_col_d;
         kb_row_q <= kb_row_d;
         read_q   <= read_d;
         frame_q  <= frame_d;
      end
   end

   assign kbCol     = kb_col_q;
   assign kbRow     = kb_row_q;
   assign read      = read_q;
   assign frameDone = frame_q;
endmodule

// File: tb/tb_keyboard_scanner.sv
// Directed bench for keyboard_scanner at default parameters (19-clock columns, 152-clock frames).
module tb_keyboard_scanner;
   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       En;
   logic [6:0] kbRowRaw;
   logic [7:0] kbCol;
   logic [6:0] kbRow;
   logic       read;
   logic       frameDone;

   logic [7:0] key_col;
   logic [6:0] key_rows;

   int checks   = 0;
   int failures = 0;

   keyboard_scanner dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .En       (En),
      .kbRowRaw (kbRowRaw),
      .kbCol    (kbCol),
      .kbRow    (kbRow),
      .read     (read),
      .frameDone(frameDone)
   );

   // Key matrix model: the held key's rows appear only while its column is driven.
   assign kbRowRaw = ((kbCol & key_col) != 8'h00) ? key_rows : 7'h00;

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_read(input int max_cyc, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < max_cyc && !ok) begin
         @(negedge Clk);
         n++;
         if (read === 1'b1) ok = 1'b1;
      end
   endtask

   initial begin
      int         n;
      bit         ok;
      int         bad, col_err, fd_err, fd_cnt, rd_cnt, scans;
      logic [7:0] exp_col, prev;

      Rst_n    = 1'b0;
      En       = 1'b0;
      key_col  = 8'h00;
      key_rows = 7'h00;
      repeat (3) @(negedge Clk);
      chk("reset_kbCol", kbCol, 8'h00);
      chk("reset_kbRow", kbRow, 7'h00);
      chk("reset_read", read, 1'b0);
      chk("reset_frameDone", frameDone, 1'b0);
      Rst_n = 1'b1;

      bad = 0;
      repeat (100) begin
         @(negedge Clk);
         if (kbCol !== 8'h00 || read !== 1'b0 || frameDone !== 1'b0) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Scan order: 17 columns (two frames plus column 0) with rows idle.
      En = 1'b1;
      col_err = 0; fd_err = 0; fd_cnt = 0; rd_cnt = 0;
      for (int t = 0; t < 17 * 19; t++) begin
         @(negedge Clk);
         exp_col = 8'h01 << ((t / 19) % 8);
         if (kbCol !== exp_col) col_err++;
         if (frameDone !== ((t > 0 && t % 152 == 0) ? 1'b1 : 1'b0)) fd_err++;
         if (frameDone === 1'b1) fd_cnt++;
         if (read === 1'b1) rd_cnt++;
      end
      chk("scan_order", col_err, 0);
      chk("frame_timing", fd_err, 0);
      chk("frame_count", fd_cnt, 2);
      chk("scan_no_read", rd_cnt, 0);

      // Clean press on column 3, then release.
      key_col  = 8'h08;
      key_rows = 7'h04;
      wait_read(1000, n, ok);
      chk("press_seen", ok, 1'b1);
      chk("press_latency", n, 514);
      chk("press_col", kbCol, 8'h08);
      chk("press_row", kbRow, 7'h04);
      key_rows = 7'h00;
      wait_read(1000, n, ok);
      chk("release_seen", ok, 1'b1);
      chk("release_interval", n, 609);
      chk("release_col", kbCol, 8'h08);
      chk("release_row", kbRow, 7'h00);
      @(negedge Clk);
      chk("read_one_cycle", read, 1'b0);
      chk("col_advance_after_read", kbCol, 8'h10);

      // Bounce: column 3 alternates 0x04/0x00 for six scans, then stays at 0x00.
      key_rows = 7'h04;
      scans = 0; rd_cnt = 0; prev = kbCol;
      for (int t = 0; t < 11 * 152 + 40; t++) begin
         @(negedge Clk);
         if (read === 1'b1) rd_cnt++;
         if (prev == 8'h08 && kbCol != 8'h08) begin
            scans++;
            key_rows = (scans < 6 && scans % 2 == 0) ? 7'h04 : 7'h00;
         end
         prev = kbCol;
      end
      chk("bounce_no_read", rd_cnt, 0);
      chk("bounce_scans", scans, 11);

      // Unused row bits and column-7 accept coinciding with frameDone.
      key_col  = 8'h80;
      key_rows = 7'h7F;
      wait_read(1000, n, ok);
      chk("col7_seen", ok, 1'b1);
      chk("col7_row_masked", kbRow, 7'h1F);
      chk("col7_col", kbCol, 8'h80);
      chk("col7_frameDone_with_read", frameDone, 1'b1);
      @(negedge Clk);
      chk("col7_frameDone_single", frameDone, 1'b0);
      chk("col7_read_single", read, 1'b0);
      chk("col_wrap", kbCol, 8'h01);

      // Reset asserted in the middle of a read cycle.
      key_col  = 8'h08;
      key_rows = 7'h12;
      wait_read(1000, n, ok);
      chk("prereset_read_seen", ok, 1'b1);
      #2 Rst_n = 1'b0;
      #1;
      chk("async_reset_read", read, 1'b0);
      chk("async_reset_kbCol", kbCol, 8'h00);
      chk("async_reset_kbRow", kbRow, 7'h00);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      chk("restart_col", kbCol, 8'h01);
      wait_read(1000, n, ok);
      chk("post_reset_read_seen", ok, 1'b1);
      chk("post_reset_latency", n, 532);
      chk("post_reset_col", kbCol, 8'h08);
      chk("post_reset_row", kbRow, 7'h12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
